uart_rx_cfg: RTL and testbench



---
 rtl/uart_rx_cfg.sv | 141 ++++++++++++++
 tb/tb_uart_rx_cfg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS data bits (LSB first), optional parity, 1-2 stop bits.
// Define UART_RX_MAJORITY_EN to take every bit decision as a 2-of-3 vote around the nominal sample point.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 521,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 rx_clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_out,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam int IDX_W = 4;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    // Vote completes one cycle after the nominal point, so the whole frame runs one cycle late.
    localparam logic [CNT_W-1:0] START_PT = CNT_W'(HALF + 1);
`else
    localparam logic [CNT_W-1:0] START_PT = CNT_W'(HALF);
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_nxt;
    logic                 sync1, l, lp;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit, ferr_acc;
    logic                 sample, fall, at_pt, last_data, last_stop, done;
    logic                 par_exp, par_err_now;

`ifdef UART_RX_MAJORITY_EN
    logic lp2;
    assign sample = (lp2 & lp) | (lp2 & l) | (lp & l);
`else
    assign sample = l;
`endif

    assign fall        = lp & ~l;
    assign at_pt       = (state == START) ? (cnt == START_PT) : (cnt == LAST);
    assign last_data   = (idx == IDX_W'(DATA_BITS - 1));
    assign last_stop   = (idx == IDX_W'(STOP_BITS - 1));
    assign par_exp     = (PARITY_MODE == 1) ? ~^shift : ^shift;
    assign par_err_now = (PARITY_MODE != 0) && (par_bit != par_exp);

    always_ff @(posedge rx_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fall) state_nxt = START;
            START:   if (at_pt) state_nxt = sample ? IDLE : DATA;
            DATA:    if (at_pt && last_data) state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
            PARITY:  if (at_pt) state_nxt = STOP;
            STOP:    if (at_pt && last_stop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rx_busy = (state != IDLE);
        done    = (state == STOP) && at_pt && last_stop;
    end

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            sync1      <= 1'b1;
            l          <= 1'b1;
            lp         <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            lp2        <= 1'b1;
`endif
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            ferr_acc   <= 1'b0;
            rx_out     <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            sync1    <= rx_in;
            l        <= sync1;
            lp       <= l;
`ifdef UART_RX_MAJORITY_EN
            lp2      <= lp;
`endif
            rx_valid <= done;
            if (done) begin
                rx_out     <= shift;
                frame_err  <= ferr_acc | ~sample;
                parity_err <= par_err_now;
            end
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    idx      <= '0;
                    ferr_acc <= 1'b0;
                end
                START: begin
                    cnt <= at_pt ? '0 : cnt + CNT_W'(1);
                    idx <= '0;
                end
                default: begin
                    if (at_pt) begin
                        cnt <= '0;
                        // LSB arrives first, so after DATA_BITS shifts bit 0 sits at shift[0].
                        if (state == DATA) begin
                            shift <= {sample, shift[DATA_BITS-1:1]};
                            idx   <= last_data ? '0 : idx + IDX_W'(1);
                        end
                        if (state == PARITY) begin
                            par_bit <= sample;
                            idx     <= '0;
                        end
                        if (state == STOP) begin
                            ferr_acc <= ferr_acc | ~sample;
                            idx      <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance, directed cases then random frames.
module tb_uart_rx_cfg;

    localparam int N = 16;

    logic       rx_clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic [7:0] out_a;
    logic [6:0] out_b;
    logic       valid_a, ferr_a, perr_a, busy_a;
    logic       valid_b, ferr_b, perr_b, busy_b;

    always #5 rx_clk = ~rx_clk;

    uart_rx_cfg #(.CLKS_PER_BIT(N)) dut_a (
        .rx_clk(rx_clk), .rst(rst), .rx_in(rx_a), .rx_out(out_a), .rx_valid(valid_a),
        .frame_err(ferr_a), .parity_err(perr_a), .rx_busy(busy_a)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(N), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
        .rx_clk(rx_clk), .rst(rst), .rx_in(rx_b), .rx_out(out_b), .rx_valid(valid_b),
        .frame_err(ferr_b), .parity_err(perr_b), .rx_busy(busy_b)
    );

    int n_cmp = 0, n_bad = 0;
    int va = 0, vb = 0;
    logic busy_pa = 1'b0, busy_pb = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe counters; busy must drop in the very cycle the strobe rises.
    always @(negedge rx_clk) begin
        if (valid_a) begin
            va++;
            chk("a_busy_drop", {30'd0, busy_pa, busy_a}, 32'b10);
        end
        if (valid_b) begin
            vb++;
            chk("b_busy_drop", {30'd0, busy_pb, busy_b}, 32'b10);
        end
        busy_pa = busy_a;
        busy_pb = busy_b;
    end

    task automatic drive(input int ch, input logic v, input int cyc);
        if (ch == 0) rx_a = v; else rx_b = v;
        repeat (cyc) @(negedge rx_clk);
    endtask

    // par < 0 means no parity bit; leaves the line at the last stop value.
    task automatic send(input int ch, input logic [8:0] d, input int nb, input int par,
                        input logic [1:0] stp, input int ns);
        drive(ch, 1'b0, N);
        for (int i = 0; i < nb; i++) drive(ch, d[i], N);
        if (par >= 0) drive(ch, par[0], N);
        for (int i = 0; i < ns; i++) drive(ch, stp[i], N);
    endtask

    task automatic expect_frame(input string tag, input int ch, input int cnt0,
                                input logic [7:0] d, input logic fe, input logic pe);
        if (ch == 0) begin
            chk({tag, "_cnt"}, va, cnt0 + 1);
            chk({tag, "_data"}, {24'd0, out_a}, {24'd0, d});
            chk({tag, "_ferr"}, {31'd0, ferr_a}, {31'd0, fe});
            chk({tag, "_perr"}, {31'd0, perr_a}, {31'd0, pe});
        end else begin
            chk({tag, "_cnt"}, vb, cnt0 + 1);
            chk({tag, "_data"}, {25'd0, out_b}, {25'd0, d[6:0]});
            chk({tag, "_ferr"}, {31'd0, ferr_b}, {31'd0, fe});
            chk({tag, "_perr"}, {31'd0, perr_b}, {31'd0, pe});
        end
    endtask

    initial begin
        int c;
        logic [7:0] d;
        logic [1:0] stp;
        logic flip, pb;
        int ch, gap;

        repeat (3) @(negedge rx_clk);
        rst = 1'b0;
        @(negedge rx_clk);
        chk("rst_out", {out_a, 1'b0, out_b, valid_a, ferr_a, perr_a, busy_a,
                        valid_b, ferr_b, perr_b, busy_b}, 32'd0);
        repeat (1000) @(negedge rx_clk);
        chk("idle_no_valid", va + vb, 0);
        chk("idle_busy", {30'd0, busy_a, busy_b}, 0);

        // 8N1 0xA5
        c = va;
        send(0, 9'h0A5, 8, -1, 2'b11, 1);
        drive(0, 1'b1, 2 * N);
        expect_frame("a5", 0, c, 8'hA5, 1'b0, 1'b0);

        // 7E2 0x41: even parity bit is 0; then flipped
        c = vb;
        send(1, 9'h041, 7, 0, 2'b11, 2);
        drive(1, 1'b1, 2 * N);
        expect_frame("p_ok", 1, c, 8'h41, 1'b0, 1'b0);
        c = vb;
        send(1, 9'h041, 7, 1, 2'b11, 2);
        drive(1, 1'b1, 2 * N);
        expect_frame("p_bad", 1, c, 8'h41, 1'b0, 1'b1);

        // Stop bit low, then break for 100 bit times: exactly one strobe
        c = va;
        send(0, 9'h03C, 8, -1, 2'b00, 1);
        drive(0, 1'b0, 100 * N);
        expect_frame("brk", 0, c, 8'h3C, 1'b1, 1'b0);
        chk("brk_busy", {31'd0, busy_a}, 0);
        drive(0, 1'b1, 2 * N);
        c = va;
        send(0, 9'h096, 8, -1, 2'b11, 1);
        drive(0, 1'b1, N);
        expect_frame("after_brk", 0, c, 8'h96, 1'b0, 1'b0);

        // Short low glitch on idle line
        c = va;
        drive(0, 1'b0, 4);
        drive(0, 1'b1, 3 * N);
        chk("glitch_cnt", va, c);
        chk("glitch_hold", {23'd0, out_a, ferr_a}, {23'd0, 8'h96, 1'b0});

`ifdef UART_RX_MAJORITY_EN
        // One-cycle high spike at the centre of data bit 3 of 0x00 is voted out
        c = va;
        drive(0, 1'b0, N);
        for (int i = 0; i < 3; i++) drive(0, 1'b0, N);
        drive(0, 1'b0, 8);
        drive(0, 1'b1, 1);
        drive(0, 1'b0, 7);
        for (int i = 4; i < 8; i++) drive(0, 1'b0, N);
        drive(0, 1'b1, 2 * N);
        expect_frame("spike", 0, c, 8'h00, 1'b0, 1'b0);
`endif

        // Reset during data bit 4, then a clean 0x5A
        c = va;
        drive(0, 1'b0, N);
        for (int i = 0; i < 4; i++) drive(0, i[0], N);
        drive(0, 1'b0, 8);
        rst = 1'b1;
        rx_a = 1'b1;
        repeat (2) @(negedge rx_clk);
        rst = 1'b0;
        @(negedge rx_clk);
        chk("midrst_out", {23'd0, out_a, busy_a}, 32'd0);
        drive(0, 1'b1, 3 * N);
        chk("midrst_no_valid", va, c);
        send(0, 9'h05A, 8, -1, 2'b11, 1);
        drive(0, 1'b1, N);
        expect_frame("post_rst", 0, c, 8'h5A, 1'b0, 1'b0);

        // Random frames on both formats, with parity and stop errors injected
        for (int k = 0; k < 24; k++) begin
            ch   = int'($urandom_range(0, 1));
            d    = 8'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            stp[0] = ($urandom_range(0, 3) != 0);
            stp[1] = ($urandom_range(0, 3) != 0);
            if (ch == 0) begin
                c = va;
                send(0, {1'b0, d}, 8, -1, stp, 1);
                expect_frame("rnd_a", 0, c, d, ~stp[0], 1'b0);
                gap = stp[0] ? int'($urandom_range(0, 2 * N)) : N + int'($urandom_range(0, N));
            end else begin
                c = vb;
                pb = (^d[6:0]) ^ flip;
                send(1, {2'b0, d[6:0]}, 7, int'(pb), stp, 2);
                expect_frame("rnd_b", 1, c, {1'b0, d[6:0]}, ~(stp[0] & stp[1]), flip);
                gap = stp[1] ? int'($urandom_range(0, 2 * N)) : N + int'($urandom_range(0, N));
            end
            drive(ch, 1'b1, gap);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
